// File: rtl/core_pkg.sv
// Shared core types: default register-file geometry and the register/tag typedefs.
package core_pkg;

  localparam int WIDTH_D = 16;
  localparam int AW_D    = 4;
  localparam int TAGW_D  = 4;

  typedef logic [AW_D-1:0]    reg_addr_t;
  typedef logic [WIDTH_D-1:0] reg_data_t;
  typedef logic [TAGW_D-1:0]  rob_tag_t;

endpackage

// File: rtl/sb_entry.sv
// One register-file entry: data, busy bit and producer tag, with per-entry port priority.
module sb_entry #(
  parameter int WIDTH = 16,
  parameter int AW    = 4,
  parameter int TAGW  = 4,
  parameter int NWR   = 3,
  parameter int NAL   = 2,
  parameter int IDX   = 0,
  parameter int ZERO  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NWR-1:0]       wen,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR*WIDTH-1:0] wdata,
  input  logic [NWR*TAGW-1:0]  wtag,
  input  logic [NAL-1:0]       alen,
  input  logic [NAL*AW-1:0]    aladdr,
  input  logic [NAL*TAGW-1:0]  altag,
  output logic [WIDTH-1:0]     data_q,
  output logic                 busy_q,
  output logic [TAGW-1:0]      tag_q,
  output logic [WIDTH-1:0]     data_d,
  output logic                 busy_d,
  output logic [TAGW-1:0]      tag_d
);

  localparam logic [AW-1:0] ADDR = AW'(IDX);
  localparam bit            LIVE = (ZERO == 0);

  logic [WIDTH-1:0] data_r, data_n;
  logic             busy_r, busy_n;
  logic [TAGW-1:0]  tag_r, tag_n;
  logic             clr;

  // Later ports overwrite earlier ones, so the highest index wins; allocate beats write-clear.
  always_comb begin
    data_n = data_r;
    busy_n = busy_r;
    tag_n  = tag_r;
    clr    = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      if (LIVE && wen[j] && (waddr[j*AW +: AW] == ADDR)) begin
        data_n = wdata[j*WIDTH +: WIDTH];
        clr    = busy_r && (tag_r == wtag[j*TAGW +: TAGW]);
      end
    end
    if (clr) busy_n = 1'b0;
    for (int k = 0; k < NAL; k++) begin
      if (LIVE && alen[k] && (aladdr[k*AW +: AW] == ADDR)) begin
        busy_n = 1'b1;
        tag_n  = altag[k*TAGW +: TAGW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= '0;
      busy_r <= 1'b0;
      tag_r  <= '0;
    end else begin
      data_r <= data_n;
      busy_r <= busy_n;
      tag_r  <= tag_n;
    end
  end

  assign data_q = LIVE ? data_r : '0;
  assign busy_q = LIVE ? busy_r : 1'b0;
  assign tag_q  = LIVE ? tag_r  : '0;
  assign data_d = LIVE ? data_n : '0;
  assign busy_d = LIVE ? busy_n : 1'b0;
  assign tag_d  = LIVE ? tag_n  : '0;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with rename scoreboard; read ports return data, busy and producer tag.
module regfile_sb
  import core_pkg::*;
#(
  parameter int WIDTH    = WIDTH_D,
  parameter int AW       = AW_D,
  parameter int NRD      = 6,
  parameter int NWR      = 3,
  parameter int NAL      = 2,
  parameter int TAGW     = TAGW_D,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    raddr_,
  output logic [NRD*WIDTH-1:0] rdata,
  output logic [NRD-1:0]       rbusy,
  output logic [NRD*TAGW-1:0]  rtag,
  input  logic [NWR-1:0]       wen,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR*WIDTH-1:0] wdata,
  input  logic [NWR*TAGW-1:0]  wtag,
  input  logic [NAL-1:0]       alen,
  input  logic [NAL*AW-1:0]    aladdr,
  input  logic [NAL*TAGW-1:0]  altag
);

  localparam int DEPTH = 2**AW;

  logic [NRD-1:0][AW-1:0] raddr_q;
  logic [WIDTH-1:0]       ent_data_q [DEPTH];
  logic                   ent_busy_q [DEPTH];
  logic [TAGW-1:0]        ent_tag_q  [DEPTH];
  logic [WIDTH-1:0]       ent_data_d [DEPTH];
  logic                   ent_busy_d [DEPTH];
  logic [TAGW-1:0]        ent_tag_d  [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) raddr_q <= '0;
    else       raddr_q <= raddr_;
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    sb_entry #(
      .WIDTH(WIDTH), .AW(AW), .TAGW(TAGW), .NWR(NWR), .NAL(NAL), .IDX(e),
      .ZERO(((ZERO_REG != 0) && (e == 0)) ? 1 : 0)
    ) u_entry (
      .clk    (clk),
      .reset  (reset),
      .wen    (wen),
      .waddr  (waddr),
      .wdata  (wdata),
      .wtag   (wtag),
      .alen   (alen),
      .aladdr (aladdr),
      .altag  (altag),
      .data_q (ent_data_q[e]),
      .busy_q (ent_busy_q[e]),
      .tag_q  (ent_tag_q[e]),
      .data_d (ent_data_d[e]),
      .busy_d (ent_busy_d[e]),
      .tag_d  (ent_tag_d[e])
    );
  end

  // The bypass view is exactly the entry's next state, so forwarding shares the priority logic.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    rtag  = '0;
    for (int i = 0; i < NRD; i++) begin
      if (BYPASS != 0) begin
        rdata[i*WIDTH +: WIDTH] = ent_data_d[raddr_q[i]];
        rbusy[i]                = ent_busy_d[raddr_q[i]];
        rtag[i*TAGW +: TAGW]    = ent_tag_d[raddr_q[i]];
      end else begin
        rdata[i*WIDTH +: WIDTH] = ent_data_q[raddr_q[i]];
        rbusy[i]                = ent_busy_q[raddr_q[i]];
        rtag[i*TAGW +: TAGW]    = ent_tag_q[raddr_q[i]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: bypass, non-bypass and zero-register instances on shared stimulus.
module tb_regfile_sb;
  import core_pkg::*;

  localparam int W = 16, AW = 4, NRD = 6, NWR = 3, NAL = 2, TW = 4;

  logic clk = 1'b0;
  logic reset;
  logic [NRD*AW-1:0] raddr_;
  logic [NWR-1:0]    wen;
  logic [NWR*AW-1:0] waddr;
  logic [NWR*W-1:0]  wdata;
  logic [NWR*TW-1:0] wtag;
  logic [NAL-1:0]    alen;
  logic [NAL*AW-1:0] aladdr;
  logic [NAL*TW-1:0] altag;

  logic [NRD*W-1:0]  rdata_b, rdata_n, rdata_z;
  logic [NRD-1:0]    rbusy_b, rbusy_n, rbusy_z;
  logic [NRD*TW-1:0] rtag_b, rtag_n, rtag_z;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1), .ZERO_REG(0)) dut (
    .clk(clk), .reset(reset), .raddr_(raddr_), .rdata(rdata_b), .rbusy(rbusy_b), .rtag(rtag_b),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wtag(wtag),
    .alen(alen), .aladdr(aladdr), .altag(altag));

  regfile_sb #(.BYPASS(0), .ZERO_REG(0)) dut_nb (
    .clk(clk), .reset(reset), .raddr_(raddr_), .rdata(rdata_n), .rbusy(rbusy_n), .rtag(rtag_n),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wtag(wtag),
    .alen(alen), .aladdr(aladdr), .altag(altag));

  regfile_sb #(.BYPASS(1), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset), .raddr_(raddr_), .rdata(rdata_z), .rbusy(rbusy_z), .rtag(rtag_z),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wtag(wtag),
    .alen(alen), .aladdr(aladdr), .altag(altag));

  typedef struct {
    int        dsel;
    int        port;
    reg_data_t data;
    logic      busy;
    rob_tag_t  tag;
    bit        chk_tag;
    string     name;
    reg_data_t act_d;
    logic      act_b;
    rob_tag_t  act_t;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Records the expectation together with the read port's output at this moment.
  function automatic void push(input int dsel, input int port, input int d, input logic b,
                               input int t, input bit ct, input string nm);
    exp_t e;
    e.dsel = dsel; e.port = port; e.data = W'(d); e.busy = b; e.tag = TW'(t);
    e.chk_tag = ct; e.name = nm;
    case (dsel)
      0:       begin e.act_d = rdata_b[port*W +: W]; e.act_b = rbusy_b[port]; e.act_t = rtag_b[port*TW +: TW]; end
      1:       begin e.act_d = rdata_n[port*W +: W]; e.act_b = rbusy_n[port]; e.act_t = rtag_n[port*TW +: TW]; end
      default: begin e.act_d = rdata_z[port*W +: W]; e.act_b = rbusy_z[port]; e.act_t = rtag_z[port*TW +: TW]; end
    endcase
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    wen = '0; waddr = '0; wdata = '0; wtag = '0;
    alen = '0; aladdr = '0; altag = '0;
  endtask

  task automatic wr(input int j, input int a, input int d, input int t);
    wen[j] = 1'b1;
    waddr[j*AW +: AW] = AW'(a);
    wdata[j*W +: W]   = W'(d);
    wtag[j*TW +: TW]  = TW'(t);
  endtask

  task automatic al(input int k, input int a, input int t);
    alen[k] = 1'b1;
    aladdr[k*AW +: AW] = AW'(a);
    altag[k*TW +: TW]  = TW'(t);
  endtask

  task automatic rd(input int p, input int a);
    raddr_[p*AW +: AW] = AW'(a);
  endtask

  task automatic test_reset();
    exp_t e;
    idle();
    reset = 1'b1;
    wr(0, 5, 16'h1234, 0);
    al(0, 5, 3);
    for (int p = 0; p < NRD; p++) rd(p, p);
    tick();
    tick();
    reset = 1'b0;
    idle();
    settle();
    for (int d = 0; d < 3; d++)
      for (int p = 0; p < NRD; p++) push(d, p, 0, 1'b0, 0, 1'b1, "rst_out");
    for (int g = 0; g < 3; g++) begin
      for (int p = 0; p < NRD; p++) rd(p, (g*NRD + p) % 16);
      tick();
      settle();
      for (int p = 0; p < NRD; p++)
        push(0, p, 0, 1'b0, 0, 1'b1, $sformatf("rst_r%0d", (g*NRD + p) % 16));
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.act_d !== e.data || e.act_b !== e.busy || (e.chk_tag && e.act_t !== e.tag)) begin
        n_bad++;
        $display("FAIL %s: dut%0d port%0d got data=%h busy=%b tag=%h, want data=%h busy=%b tag=%h",
                 e.name, e.dsel, e.port, e.act_d, e.act_b, e.act_t, e.data, e.busy, e.tag);
      end
    end
  endtask

  task automatic test_alloc_commit();
    exp_t e;
    rd(0, 3);
    al(0, 3, 5);
    tick();
    idle();
    settle();
    push(0, 0, 0, 1'b1, 5, 1'b1, "ac_alloc");
    push(1, 0, 0, 1'b1, 5, 1'b1, "ac_alloc_nb");
    wr(0, 3, 16'h1234, 5);
    settle();
    push(0, 0, 16'h1234, 1'b0, 0, 1'b0, "ac_commit_byp");
    push(1, 0, 0, 1'b1, 5, 1'b1, "ac_commit_nb_old");
    tick();
    idle();
    settle();
    push(0, 0, 16'h1234, 1'b0, 0, 1'b0, "ac_after");
    push(1, 0, 16'h1234, 1'b0, 0, 1'b0, "ac_after_nb");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.act_d !== e.data || e.act_b !== e.busy || (e.chk_tag && e.act_t !== e.tag)) begin
        n_bad++;
        $display("FAIL %s: dut%0d port%0d got data=%h busy=%b tag=%h, want data=%h busy=%b tag=%h",
                 e.name, e.dsel, e.port, e.act_d, e.act_b, e.act_t, e.data, e.busy, e.tag);
      end
    end
  endtask

  task automatic test_stale_tag();
    exp_t e;
    rd(1, 3);
    al(0, 3, 5);
    tick();
    idle();
    al(0, 3, 7);
    tick();
    idle();
    wr(0, 3, 16'hAAAA, 5);
    tick();
    idle();
    settle();
    push(0, 1, 16'hAAAA, 1'b1, 7, 1'b1, "stale_commit");
    push(1, 1, 16'hAAAA, 1'b1, 7, 1'b1, "stale_commit_nb");
    wr(0, 3, 16'hBBBB, 7);
    tick();
    idle();
    settle();
    push(0, 1, 16'hBBBB, 1'b0, 0, 1'b0, "fresh_commit");
    push(1, 1, 16'hBBBB, 1'b0, 0, 1'b0, "fresh_commit_nb");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.act_d !== e.data || e.act_b !== e.busy || (e.chk_tag && e.act_t !== e.tag)) begin
        n_bad++;
        $display("FAIL %s: dut%0d port%0d got data=%h busy=%b tag=%h, want data=%h busy=%b tag=%h",
                 e.name, e.dsel, e.port, e.act_d, e.act_b, e.act_t, e.data, e.busy, e.tag);
      end
    end
  endtask

  task automatic test_conflicts();
    exp_t e;
    rd(2, 2);
    rd(3, 4);
    rd(4, 6);
    tick();
    wr(0, 2, 16'h1111, 0);
    wr(2, 2, 16'h2222, 0);
    al(0, 4, 1);
    al(1, 4, 2);
    settle();
    push(0, 2, 16'h2222, 1'b0, 0, 1'b0, "ww_byp");
    push(0, 3, 0, 1'b1, 2, 1'b1, "aa_byp");
    push(1, 3, 0, 1'b0, 0, 1'b0, "aa_nb_old");
    tick();
    idle();
    settle();
    push(0, 2, 16'h2222, 1'b0, 0, 1'b0, "ww");
    push(1, 2, 16'h2222, 1'b0, 0, 1'b0, "ww_nb");
    push(0, 3, 0, 1'b1, 2, 1'b1, "aa");
    push(1, 3, 0, 1'b1, 2, 1'b1, "aa_nb");
    wr(1, 6, 16'h5555, 0);
    al(1, 6, 9);
    settle();
    push(0, 4, 16'h5555, 1'b1, 9, 1'b1, "wa_byp");
    tick();
    idle();
    settle();
    push(1, 4, 16'h5555, 1'b1, 9, 1'b1, "wa_nb");
    wr(0, 6, 16'h6666, 9);
    al(0, 6, 10);
    settle();
    push(0, 4, 16'h6666, 1'b1, 10, 1'b1, "clr_vs_alloc_byp");
    push(1, 4, 16'h5555, 1'b1, 9, 1'b1, "clr_vs_alloc_nb_old");
    tick();
    idle();
    settle();
    push(1, 4, 16'h6666, 1'b1, 10, 1'b1, "clr_vs_alloc_nb");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.act_d !== e.data || e.act_b !== e.busy || (e.chk_tag && e.act_t !== e.tag)) begin
        n_bad++;
        $display("FAIL %s: dut%0d port%0d got data=%h busy=%b tag=%h, want data=%h busy=%b tag=%h",
                 e.name, e.dsel, e.port, e.act_d, e.act_b, e.act_t, e.data, e.busy, e.tag);
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    rd(5, 9);
    tick();
    wr(1, 9, 16'hBEEF, 0);
    settle();
    push(0, 5, 16'hBEEF, 1'b0, 0, 1'b0, "byp_same_cycle");
    push(1, 5, 0, 1'b0, 0, 1'b0, "nb_same_cycle_old");
    tick();
    idle();
    settle();
    push(1, 5, 16'hBEEF, 1'b0, 0, 1'b0, "nb_next_cycle");
    push(0, 5, 16'hBEEF, 1'b0, 0, 1'b0, "byp_held");
    wr(0, 9, 16'h0001, 0);
    wr(2, 9, 16'hC0DE, 0);
    settle();
    push(0, 5, 16'hC0DE, 1'b0, 0, 1'b0, "byp_high_port");
    tick();
    idle();
    settle();
    push(1, 5, 16'hC0DE, 1'b0, 0, 1'b0, "nb_high_port");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.act_d !== e.data || e.act_b !== e.busy || (e.chk_tag && e.act_t !== e.tag)) begin
        n_bad++;
        $display("FAIL %s: dut%0d port%0d got data=%h busy=%b tag=%h, want data=%h busy=%b tag=%h",
                 e.name, e.dsel, e.port, e.act_d, e.act_b, e.act_t, e.data, e.busy, e.tag);
      end
    end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    rd(0, 0);
    tick();
    wr(0, 0, 16'hFFFF, 0);
    al(0, 0, 3);
    settle();
    push(2, 0, 0, 1'b0, 0, 1'b1, "zero_byp");
    push(0, 0, 16'hFFFF, 1'b1, 3, 1'b1, "r0_live_byp");
    tick();
    idle();
    settle();
    push(2, 0, 0, 1'b0, 0, 1'b1, "zero_after");
    push(0, 0, 16'hFFFF, 1'b1, 3, 1'b1, "r0_live");
    push(1, 0, 16'hFFFF, 1'b1, 3, 1'b1, "r0_live_nb");
    push(2, 5, 16'hC0DE, 1'b0, 0, 1'b0, "zero_dut_r9");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.act_d !== e.data || e.act_b !== e.busy || (e.chk_tag && e.act_t !== e.tag)) begin
        n_bad++;
        $display("FAIL %s: dut%0d port%0d got data=%h busy=%b tag=%h, want data=%h busy=%b tag=%h",
                 e.name, e.dsel, e.port, e.act_d, e.act_b, e.act_t, e.data, e.busy, e.tag);
      end
    end
  endtask

  task automatic test_reset_busy();
    exp_t e;
    for (int r = 1; r <= 15; r += 2) begin
      al(0, r, r);
      if (r < 15) al(1, r + 1, r + 1);
      tick();
      idle();
    end
    for (int p = 0; p < NRD; p++) rd(p, 10 + p);
    tick();
    settle();
    for (int p = 0; p < NRD; p++)
      push(0, p, 0, 1'b1, 10 + p, 1'b1, $sformatf("busy_r%0d", 10 + p));
    reset = 1'b1;
    al(0, 12, 1);
    wr(0, 11, 16'h7777, 11);
    tick();
    reset = 1'b0;
    idle();
    settle();
    for (int d = 0; d < 3; d++)
      for (int p = 0; p < NRD; p++) push(d, p, 0, 1'b0, 0, 1'b1, "rst2_out");
    for (int g = 0; g < 3; g++) begin
      for (int p = 0; p < NRD; p++) rd(p, 1 + ((g*NRD + p) % 15));
      tick();
      settle();
      for (int p = 0; p < NRD; p++)
        push(g % 3, p, 0, 1'b0, 0, 1'b1, $sformatf("rst2_r%0d", 1 + ((g*NRD + p) % 15)));
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.act_d !== e.data || e.act_b !== e.busy || (e.chk_tag && e.act_t !== e.tag)) begin
        n_bad++;
        $display("FAIL %s: dut%0d port%0d got data=%h busy=%b tag=%h, want data=%h busy=%b tag=%h",
                 e.name, e.dsel, e.port, e.act_d, e.act_b, e.act_t, e.data, e.busy, e.tag);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    raddr_ = '0;
    idle();
    test_reset();
    test_alloc_commit();
    test_stale_tag();
    test_conflicts();
    test_bypass();
    test_zero_reg();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
